regfile_sb: RTL and testbench

Parametrised multi-port integer register file with write-through bypass and a per-register busy scoreboard. It replaces the single-write, dual-read register file in the core's decode/writeback path. It supports configurable width, depth and read/write port counts. Issue logic uses the scoreboard to detect pending producers (RAW/WAW) without a separate hazard unit.

---
 rtl/regfile_sb.sv | 89 ++++++++
 tb/tb_regfile_sb.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with optional write-through bypass
// and a per-register busy scoreboard for RAW/WAW detection at issue.
`default_nettype none

module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  output logic                 iss_busy,
  output logic [NREGS-1:0]     busy_vec
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;

  // Ascending port order: the last assignment (highest port) wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wr_en[k] && (wr_addr[k*AW +: AW] != '0))
          regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
      end
    end
  end

  // Issue overrides a same-cycle write: the new producer supersedes the old.
  always_comb begin
    busy_nxt = busy_q;
    for (int k = 0; k < NWR; k++) begin
      if (wr_en[k]) busy_nxt[wr_addr[k*AW +: AW]] = 1'b0;
    end
    if (iss_en) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  generate
    for (genvar p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] data;
      logic            busy;

      assign a = rd_addr[p*AW +: AW];

      always_comb begin
        data = regs[a];
        busy = busy_q[a];
        if ((BYPASS != 0) && rst_n && (a != '0)) begin
          for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] == a)) begin
              data = wr_data[k*XLEN +: XLEN];
              busy = 1'b0;
            end
          end
        end
      end

      assign rd_data[p*XLEN +: XLEN] = data;
      assign rd_busy[p]              = busy;
    end
  endgenerate

  assign iss_busy = busy_q[iss_addr];
  assign busy_vec = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed plus random checks of regfile_sb (BYPASS on and off)
// against an array-based reference model.
`default_nettype none

module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  wr_en = '0;
  logic [9:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [9:0]  rd_addr = '0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;

  logic [63:0] rd_data_b, rd_data_nb;
  logic [1:0]  rd_busy_b, rd_busy_nb;
  logic        iss_busy_b, iss_busy_nb;
  logic [31:0] busy_vec_b, busy_vec_nb;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem [32];
  logic [31:0] bv;

  always #5 clk = ~clk;

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_busy(iss_busy_b), .busy_vec(busy_vec_b)
  );

  regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_busy(iss_busy_nb), .busy_vec(busy_vec_nb)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    bv = '0;
  endtask

  // Expected outputs derived from the model state and the current inputs.
  task automatic check_comb();
    logic [4:0]  a;
    logic [31:0] eb, en;
    logic        bb, bn;
    bit          hit;
    for (int p = 0; p < 2; p++) begin
      a   = rd_addr[p*5 +: 5];
      en  = mem[a];
      bn  = bv[a];
      eb  = en;
      bb  = bn;
      hit = 0;
      if (rst_n && a != 5'd0) begin
        for (int k = 1; k >= 0; k--) begin
          if (!hit && wr_en[k] && wr_addr[k*5 +: 5] == a) begin
            hit = 1;
            eb  = wr_data[k*32 +: 32];
            bb  = 1'b0;
          end
        end
      end
      chk($sformatf("rd_data_byp[%0d] x%0d", p, a), 64'(rd_data_b[p*32 +: 32]), 64'(eb));
      chk($sformatf("rd_busy_byp[%0d] x%0d", p, a), 64'(rd_busy_b[p]), 64'(bb));
      chk($sformatf("rd_data_nobyp[%0d] x%0d", p, a), 64'(rd_data_nb[p*32 +: 32]), 64'(en));
      chk($sformatf("rd_busy_nobyp[%0d] x%0d", p, a), 64'(rd_busy_nb[p]), 64'(bn));
    end
    chk("iss_busy_byp", 64'(iss_busy_b), 64'(bv[iss_addr]));
    chk("iss_busy_nobyp", 64'(iss_busy_nb), 64'(bv[iss_addr]));
    chk("busy_vec_byp", 64'(busy_vec_b), 64'(bv));
    chk("busy_vec_nobyp", 64'(busy_vec_nb), 64'(bv));
  endtask

  task automatic model_update();
    logic [31:0] nb;
    logic [4:0]  wa;
    nb = bv;
    for (int k = 0; k < 2; k++) begin
      wa = wr_addr[k*5 +: 5];
      if (wr_en[k] && wa != 5'd0) begin
        mem[wa] = wr_data[k*32 +: 32];
        nb[wa]  = 1'b0;
      end
    end
    if (iss_en && iss_addr != 5'd0) nb[iss_addr] = 1'b1;
    bv = nb;
  endtask

  task automatic drive(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                       input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] r0, input logic [4:0] r1,
                       input logic ie, input logic [4:0] ia);
    wr_en    = we;
    wr_addr  = {a1, a0};
    wr_data  = {d1, d0};
    rd_addr  = {r1, r0};
    iss_en   = ie;
    iss_addr = ia;
  endtask

  task automatic settle();
    #4;
    check_comb();
  endtask

  task automatic adv();
    @(posedge clk);
    if (rst_n) model_update();
    #1;
  endtask

  task automatic tick();
    settle();
    adv();
  endtask

  initial begin
    model_reset();

    // Reset state visible on every register through both ports.
    for (int r = 0; r < 32; r++) begin
      rd_addr = {5'(r), 5'(r)};
      #1;
      check_comb();
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // x5 written, then an asynchronous reset mid-cycle clears it at once.
    drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 5'd5, 1'b0, 5'd0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1, 5'd5);
    settle();
    chk("x5_before_reset", 64'(rd_data_b[31:0]), 64'h0000_0000_DEAD_BEEF);
    drive(2'b11, 5'd5, 32'hCAFE, 5'd6, 32'hBEEF, 5'd5, 5'd6, 1'b1, 5'd7);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_comb();
    chk("x5_in_reset", 64'(rd_data_nb[31:0]), 64'h0);
    adv();
    check_comb();
    rst_n = 1'b1;

    // Register 0 ignores writes and issues.
    drive(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0);
    settle();
    chk("x0_read", 64'(rd_data_b[63:32]), 64'h0);
    chk("x0_busy", 64'(busy_vec_b[0]), 64'h0);
    adv();

    // x7 written, read on both ports next cycle.
    drive(2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0, 5'd1, 5'd2, 1'b0, 5'd0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b0, 5'd0);
    settle();
    chk("x7_p0", 64'(rd_data_b[31:0]), 64'hA5A5A5A5);
    chk("x7_p1", 64'(rd_data_nb[63:32]), 64'hA5A5A5A5);
    adv();

    // Same-cycle write/read of x3: bypassed vs stored value.
    drive(2'b01, 5'd3, 32'h33, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0);
    tick();
    drive(2'b10, 5'd0, 32'h0, 5'd3, 32'h55, 5'd3, 5'd3, 1'b0, 5'd0);
    settle();
    chk("x3_bypass", 64'(rd_data_b[31:0]), 64'h55);
    chk("x3_nobypass_old", 64'(rd_data_nb[31:0]), 64'h33);
    adv();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b0, 5'd0);
    settle();
    chk("x3_nobypass_next", 64'(rd_data_nb[63:32]), 64'h55);
    adv();

    // Port collision on x9 (highest port wins), then distinct x9/x10.
    drive(2'b11, 5'd9, 32'h11, 5'd9, 32'h22, 5'd9, 5'd10, 1'b0, 5'd0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd10, 1'b0, 5'd0);
    settle();
    chk("x9_collision", 64'(rd_data_nb[31:0]), 64'h22);
    adv();
    drive(2'b11, 5'd9, 32'h99, 5'd10, 32'h1010, 5'd9, 5'd10, 1'b0, 5'd0);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd10, 1'b0, 5'd0);
    settle();
    chk("x9_stored", 64'(rd_data_nb[31:0]), 64'h99);
    chk("x10_stored", 64'(rd_data_nb[63:32]), 64'h1010);
    adv();

    // Scoreboard: issue x4, re-issue (WAW), write to clear.
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b1, 5'd4);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b1, 5'd4);
    settle();
    chk("x4_rd_busy", 64'(rd_busy_b[0]), 64'h1);
    chk("x4_iss_busy", 64'(iss_busy_b), 64'h1);
    adv();
    drive(2'b01, 5'd4, 32'h44, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, 5'd4);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 5'd4, 1'b0, 5'd4);
    settle();
    chk("x4_cleared", 64'(busy_vec_nb[4]), 64'h0);
    adv();

    // Issue and write of x6 in the same cycle: issue wins.
    drive(2'b01, 5'd6, 32'h77, 5'd0, 32'h0, 5'd6, 5'd6, 1'b1, 5'd6);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd6, 5'd6, 1'b0, 5'd6);
    settle();
    chk("x6_data", 64'(rd_data_nb[31:0]), 64'h77);
    chk("x6_busy", 64'(busy_vec_b[6]), 64'h1);
    adv();
    drive(2'b10, 5'd0, 32'h0, 5'd6, 32'h78, 5'd6, 5'd6, 1'b0, 5'd6);
    tick();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd6, 5'd6, 1'b0, 5'd6);
    settle();
    chk("x6_cleared", 64'(busy_vec_b[6]), 64'h0);
    adv();

    // Random traffic on a narrow address range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom), 5'($urandom_range(0, 15)), $urandom,
            5'($urandom_range(0, 15)), $urandom,
            5'($urandom_range(0, 15)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 15)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
